// File: rtl/tube_host_master_if.sv
// ----------------------------------------------------------------------------
// tube_host_master_if
// Bundles the command/response handshake and the ULA host-port signals of
// tube_host_master.
//   master : the bus initiator (tube_host_master itself)
//   slave  : the environment (command source, response sink and ULA host port)
// Signals:
//   CMD_VALID/CMD_READY/CMD_REG/CMD_WRITE/CMD_DATA : command request
//   RSP_VALID/RSP_DATA/RSP_ERR                     : completion response
//   HCS/HA/HRW/HDOUT/HDOE                          : drive to ULA host port
//   HDIN                                           : data returned by ULA
// ----------------------------------------------------------------------------
interface tube_host_master_if;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [2:0] CMD_REG;
  logic       CMD_WRITE;
  logic [7:0] CMD_DATA;
  logic       RSP_VALID;
  logic [7:0] RSP_DATA;
  logic       RSP_ERR;
  logic       HCS;
  logic [2:0] HA;
  logic       HRW;
  logic [7:0] HDOUT;
  logic       HDOE;
  logic [7:0] HDIN;

  modport master (
    input  CMD_VALID, CMD_REG, CMD_WRITE, CMD_DATA, HDIN,
    output CMD_READY, RSP_VALID, RSP_DATA, RSP_ERR,
    output HCS, HA, HRW, HDOUT, HDOE
  );

  modport slave (
    output CMD_VALID, CMD_REG, CMD_WRITE, CMD_DATA, HDIN,
    input  CMD_READY, RSP_VALID, RSP_DATA, RSP_ERR,
    input  HCS, HA, HRW, HDOUT, HDOE
  );
endinterface

// File: rtl/tube_host_master.sv
// ----------------------------------------------------------------------------
// tube_host_master
// Host-side bus initiator for the tube_ula host port. Accepts byte commands
// and performs them on the ULA: Tube registers R1-R4 are status-polled (read
// the status address until the relevant flag is set, one idle clock between
// bus cycles, then access the data address); register 0 (control) is accessed
// directly with a single bus cycle.
//
// Ports:
//   HO2  : bus clock, one clock per host bus cycle
//   RST  : synchronous active-high reset
//   bus  : tube_host_master_if.master (command, response and ULA host port)
//
// Parameters:
//   POLL_WIDTH : width of the saturating poll counter
//   POLL_LIMIT : status polls allowed before a command aborts
//
// Build option:
//   TUBE_HOST_TIMEOUT_EN : when defined, a command whose status flag is still
//   clear after POLL_LIMIT polls completes with RSP_ERR=1 and RSP_DATA equal
//   to the last status byte. When undefined, polling never gives up and
//   RSP_ERR stays 0.
// ----------------------------------------------------------------------------
module tube_host_master #(
  parameter int POLL_WIDTH = 8,
  parameter int POLL_LIMIT = 255
) (
  input logic                HO2,
  input logic                RST,
  tube_host_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POLL  = 3'd1,
    S_CHECK = 3'd2,
    S_XFER  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [POLL_WIDTH-1:0] POLL_MAX = {POLL_WIDTH{1'b1}};

  // ULA host address for register n (1..4): status at 2(n-1), data at 2(n-1)+1.
  // Register 0 is the control register at address 000.
  function automatic logic [2:0] tube_addr(input logic [2:0] reg_n, input logic is_data);
    logic [1:0] idx;
    idx = reg_n[1:0] - 2'd1;  // 1..4 -> 0..3 (4 = 3'b100 wraps to 2'b11)
    if (reg_n == 3'd0) begin
      tube_addr = 3'd0;
    end else begin
      tube_addr = {idx, is_data};
    end
  endfunction

  state_e                state_q, state_d;
  logic [2:0]            reg_q, reg_d;
  logic                  write_q, write_d;
  logic [7:0]            data_q, data_d;
  logic [7:0]            status_q, status_d;
  logic [POLL_WIDTH-1:0] poll_cnt_q, poll_cnt_d;
  logic                  hcs_q, hcs_d;
  logic [2:0]            ha_q, ha_d;
  logic                  hrw_q, hrw_d;
  logic [7:0]            hdout_q, hdout_d;
  logic                  hdoe_q, hdoe_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [7:0]            rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;

  logic                  ready_s;
  logic                  accept_s;
  logic [2:0]            cmd_reg_s;
  logic                  flag_s;
  logic                  timeout_s;

  assign ready_s   = (state_q == S_IDLE) && !RST;
  assign accept_s  = bus.CMD_VALID && ready_s;
  // Reserved register numbers 5-7 behave as the control register.
  assign cmd_reg_s = (bus.CMD_REG > 3'd4) ? 3'd0 : bus.CMD_REG;
  // Writes wait for "not full" (bit 6), reads for "data available" (bit 7).
  assign flag_s    = write_q ? status_q[6] : status_q[7];

`ifdef TUBE_HOST_TIMEOUT_EN
  localparam logic [POLL_WIDTH-1:0] POLL_LAST = POLL_WIDTH'(POLL_LIMIT - 1);
  // The poll just checked was the last one allowed.
  assign timeout_s = (poll_cnt_q == POLL_LAST);
`else
  // POLL_LIMIT has no effect without the timeout option.
  logic [POLL_WIDTH-1:0] unused_limit_s;
  assign unused_limit_s = POLL_WIDTH'(POLL_LIMIT);
  assign timeout_s      = 1'b0;
`endif

  // Next-state logic, then registered-output decode from the next state so
  // that the bus pins line up with the state they belong to.
  always_comb begin
    state_d     = state_q;
    reg_d       = reg_q;
    write_d     = write_q;
    data_d      = data_q;
    status_d    = status_q;
    poll_cnt_d  = poll_cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = 1'b0;
    hcs_d       = 1'b1;
    ha_d        = ha_q;
    hrw_d       = hrw_q;
    hdout_d     = hdout_q;
    hdoe_d      = 1'b0;
    rsp_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          reg_d      = cmd_reg_s;
          write_d    = bus.CMD_WRITE;
          data_d     = bus.CMD_DATA;
          poll_cnt_d = {POLL_WIDTH{1'b0}};
          state_d    = (cmd_reg_s == 3'd0) ? S_XFER : S_POLL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_POLL: begin
        status_d = bus.HDIN;
        state_d  = S_CHECK;
      end
      S_CHECK: begin
        if (flag_s) begin
          state_d = S_XFER;
        end else if (timeout_s) begin
          state_d    = S_DONE;
          rsp_err_d  = 1'b1;
          rsp_data_d = status_q;
        end else begin
          state_d = S_POLL;
          if (poll_cnt_q != POLL_MAX) begin
            poll_cnt_d = poll_cnt_q + POLL_WIDTH'(1);
          end else begin
            poll_cnt_d = poll_cnt_q;
          end
        end
      end
      S_XFER: begin
        if (!write_q) begin
          rsp_data_d = bus.HDIN;
        end else begin
          rsp_data_d = rsp_data_q;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    case (state_d)
      S_POLL: begin
        hcs_d = 1'b0;
        ha_d  = tube_addr(reg_d, 1'b0);
        hrw_d = 1'b1;
      end
      S_XFER: begin
        hcs_d = 1'b0;
        ha_d  = tube_addr(reg_d, 1'b1);
        hrw_d = ~write_d;
        if (write_d) begin
          hdout_d = data_d;
          hdoe_d  = 1'b1;
        end else begin
          hdout_d = hdout_q;
          hdoe_d  = 1'b0;
        end
      end
      S_DONE: begin
        rsp_valid_d = 1'b1;
      end
      default: begin
        hcs_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge HO2) begin
    if (RST) begin
      state_q     <= S_IDLE;
      reg_q       <= 3'd0;
      write_q     <= 1'b0;
      data_q      <= 8'h00;
      status_q    <= 8'h00;
      poll_cnt_q  <= {POLL_WIDTH{1'b0}};
      hcs_q       <= 1'b1;
      ha_q        <= 3'd0;
      hrw_q       <= 1'b1;
      hdout_q     <= 8'h00;
      hdoe_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      reg_q       <= reg_d;
      write_q     <= write_d;
      data_q      <= data_d;
      status_q    <= status_d;
      poll_cnt_q  <= poll_cnt_d;
      hcs_q       <= hcs_d;
      ha_q        <= ha_d;
      hrw_q       <= hrw_d;
      hdout_q     <= hdout_d;
      hdoe_q      <= hdoe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.CMD_READY = ready_s;
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RSP_DATA  = rsp_data_q;
  assign bus.RSP_ERR   = rsp_err_q;
  assign bus.HCS       = hcs_q;
  assign bus.HA        = ha_q;
  assign bus.HRW       = hrw_q;
  assign bus.HDOUT     = hdout_q;
  assign bus.HDOE      = hdoe_q;

endmodule

// File: tb/tb_tube_host_master.sv
// ----------------------------------------------------------------------------
// tb_tube_host_master
// Directed bench for tube_host_master. A behavioural model turns each
// accepted command into the list of per-clock bus beats and the response the
// spec's rules demand; a negedge compare process checks the DUT against the
// head of that list every clock and also plays the ULA by driving HDIN from
// the same beat. Directed tests add literal expectations (latencies, poll
// counts, data bytes) that pin the model.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tube_host_master;
  localparam int TB_LIMIT = 4;

  logic HO2 = 1'b0;
  logic RST;

  tube_host_master_if bus ();

  tube_host_master #(.POLL_WIDTH(8), .POLL_LIMIT(TB_LIMIT)) dut (
    .HO2 (HO2),
    .RST (RST),
    .bus (bus)
  );

  always #5 HO2 = ~HO2;

  typedef struct packed {
    logic       hcs;
    logic [2:0] ha;
    logic       hrw;
    logic       hdoe;
    logic [7:0] hdout;
    logic       rv;
    logic [7:0] rd;
    logic       err;
    logic [7:0] hdin;
  } beat_t;

  beat_t      exq[$];
  logic [7:0] m_rsp_data = 8'h00;
  logic [7:0] script[$];
  logic [7:0] rd_byte;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         n_acc = 0;
  int         acc_cyc = 0;
  int         rv_cyc = 0;
  int         last_lat = 0;
  logic       last_err = 1'b0;
  int         lo_cnt[8];
  logic [7:0] wr_seen[$];
  int         rv_cnt = 0;
  logic       prev_lo = 1'b0;
  logic       started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic beat_t idle_beat();
    beat_t b;
    b.hcs   = 1'b1;
    b.ha    = 3'd0;
    b.hrw   = 1'b1;
    b.hdoe  = 1'b0;
    b.hdout = 8'h00;
    b.rv    = 1'b0;
    b.rd    = m_rsp_data;
    b.err   = 1'b0;
    b.hdin  = 8'hC3;  // both flags set: a DUT sampling HDIN off-cycle is caught
    return b;
  endfunction

  // Expected beats for one command, from the accept edge to the response.
  function automatic void push_cmd(input logic [2:0] r, input logic wr, input logic [7:0] d);
    beat_t      b;
    int         n;
    int         base;
    logic [7:0] st;
    logic       ok;
    logic       err;
    logic [7:0] newd;
    n    = (r > 3'd4) ? 0 : int'(r);
    base = (n == 0) ? 0 : (n - 1) * 2;
    ok   = 1'b1;
    err  = 1'b0;
    newd = m_rsp_data;
    if (n != 0) begin
      ok = 1'b0;
      for (int k = 0; k < 1000; k++) begin
        st     = script[(k < script.size()) ? k : script.size() - 1];
        b      = idle_beat();
        b.hcs  = 1'b0;
        b.ha   = 3'(base);
        b.hrw  = 1'b1;
        b.hdin = st;
        exq.push_back(b);
        exq.push_back(idle_beat());
        if (wr ? st[6] : st[7]) begin
          ok = 1'b1;
          break;
        end
`ifdef TUBE_HOST_TIMEOUT_EN
        if (k == TB_LIMIT - 1) begin
          err  = 1'b1;
          newd = st;
          break;
        end
`endif
      end
    end
    if (ok) begin
      b       = idle_beat();
      b.hcs   = 1'b0;
      b.ha    = (n == 0) ? 3'd0 : 3'(base + 1);
      b.hrw   = ~wr;
      b.hdoe  = wr;
      b.hdout = d;
      b.hdin  = rd_byte;
      exq.push_back(b);
      newd = wr ? m_rsp_data : rd_byte;
    end
    b     = idle_beat();
    b.rv  = 1'b1;
    b.rd  = newd;
    b.err = err;
    exq.push_back(b);
    m_rsp_data = newd;
  endfunction

  // Model clock: consume one beat per clock, or accept a new command when idle.
  always @(posedge HO2) begin
    cyc++;
    if (RST) begin
      exq.delete();
      m_rsp_data = 8'h00;
      started    = 1'b1;
    end else if (exq.size() > 0) begin
      void'(exq.pop_front());
    end else if (bus.CMD_VALID === 1'b1) begin
      push_cmd(bus.CMD_REG, bus.CMD_WRITE, bus.CMD_DATA);
      n_acc++;
      acc_cyc = cyc;
    end
  end

  // Compare process and ULA responder, mid-cycle.
  always @(negedge HO2) begin
    beat_t e;
    logic  lo;
    e = (exq.size() > 0) ? exq[0] : idle_beat();
    if (started) begin
      chk("CMD_READY", 32'(bus.CMD_READY), 32'((exq.size() == 0) && !RST));
      chk("HCS", 32'(bus.HCS), 32'(e.hcs));
      chk("HDOE", 32'(bus.HDOE), 32'(e.hdoe));
      chk("RSP_VALID", 32'(bus.RSP_VALID), 32'(e.rv));
      chk("RSP_DATA", 32'(bus.RSP_DATA), 32'(e.rd));
      chk("RSP_ERR", 32'(bus.RSP_ERR), 32'(e.err));
      if (!e.hcs) begin
        chk("HA", 32'(bus.HA), 32'(e.ha));
        chk("HRW", 32'(bus.HRW), 32'(e.hrw));
      end
      if (e.hdoe) begin
        chk("HDOUT", 32'(bus.HDOUT), 32'(e.hdout));
      end
      lo = (bus.HCS === 1'b0);
      chk("HCS_gap", 32'(prev_lo && lo), 32'd0);
      prev_lo = lo;
      if (lo) lo_cnt[bus.HA]++;
      if (bus.HDOE === 1'b1) wr_seen.push_back(bus.HDOUT);
      if (bus.RSP_VALID === 1'b1) begin
        rv_cnt++;
        rv_cyc   = cyc;
        last_lat = cyc - acc_cyc + 1;
        last_err = bus.RSP_ERR;
      end
    end
    bus.HDIN = e.hdin;
  end

  task automatic step();
    @(posedge HO2);
    #2;
  endtask

  task automatic clr_mon();
    for (int i = 0; i < 8; i++) lo_cnt[i] = 0;
    wr_seen.delete();
    rv_cnt = 0;
  endtask

  task automatic issue(input logic [2:0] r, input logic w, input logic [7:0] d, input logic keep);
    int a0;
    a0            = n_acc;
    bus.CMD_VALID = 1'b1;
    bus.CMD_REG   = r;
    bus.CMD_WRITE = w;
    bus.CMD_DATA  = d;
    for (int k = 0; k < 50 && n_acc == a0; k++) step();
    chk("accept", 32'(n_acc - a0), 32'd1);
    if (!keep) bus.CMD_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300 && exq.size() != 0; k++) step();
    chk("done_in_time", 32'(exq.size()), 32'd0);
  endtask

  int lo_total;

  initial begin
    RST           = 1'b1;
    bus.CMD_VALID = 1'b0;
    bus.CMD_REG   = 3'd0;
    bus.CMD_WRITE = 1'b0;
    bus.CMD_DATA  = 8'h00;
    script        = '{8'h40};
    rd_byte       = 8'h00;
    repeat (3) @(posedge HO2);
    @(negedge HO2);
    #1;
    chk("rst_HCS", 32'(bus.HCS), 32'd1);
    chk("rst_HA", 32'(bus.HA), 32'd0);
    chk("rst_HRW", 32'(bus.HRW), 32'd1);
    chk("rst_HDOUT", 32'(bus.HDOUT), 32'h00);
    chk("rst_HDOE", 32'(bus.HDOE), 32'd0);
    chk("rst_RSP_VALID", 32'(bus.RSP_VALID), 32'd0);
    chk("rst_RSP_DATA", 32'(bus.RSP_DATA), 32'h00);
    chk("rst_RSP_ERR", 32'(bus.RSP_ERR), 32'd0);
    chk("rst_CMD_READY", 32'(bus.CMD_READY), 32'd0);
    step();
    RST = 1'b0;
    step();

    // R1 write 0xAA, status immediately not-full.
    clr_mon();
    script = '{8'h40};
    issue(3'd1, 1'b1, 8'hAA, 1'b0);
    wait_idle();
    chk("r1w_latency", 32'(last_lat), 32'd4);
    chk("r1w_status_polls", 32'(lo_cnt[0]), 32'd1);
    chk("r1w_data_cycles", 32'(lo_cnt[1]), 32'd1);
    chk("r1w_hdout", 32'((wr_seen.size() == 1) ? wr_seen[0] : 8'h00), 32'hAA);
    chk("r1w_rsp_count", 32'(rv_cnt), 32'd1);

    // R4 read: three empty polls, then data available.
    clr_mon();
    script  = '{8'h00, 8'h00, 8'h00, 8'h80};
    rd_byte = 8'h5C;
    issue(3'd4, 1'b0, 8'h00, 1'b0);
    wait_idle();
    chk("r4r_latency", 32'(last_lat), 32'd10);
    chk("r4r_status_polls", 32'(lo_cnt[6]), 32'd4);
    chk("r4r_data_cycles", 32'(lo_cnt[7]), 32'd1);
    chk("r4r_rsp_data", 32'(bus.RSP_DATA), 32'h5C);

    // Control write: no polling, one bus cycle, read data untouched.
    clr_mon();
    issue(3'd0, 1'b1, 8'hA0, 1'b0);
    wait_idle();
    lo_total = 0;
    for (int i = 0; i < 8; i++) lo_total += lo_cnt[i];
    chk("ctl_latency", 32'(last_lat), 32'd2);
    chk("ctl_bus_cycles", 32'(lo_total), 32'd1);
    chk("ctl_hdout", 32'((wr_seen.size() == 1) ? wr_seen[0] : 8'h00), 32'hA0);
    chk("ctl_rsp_data_kept", 32'(bus.RSP_DATA), 32'h5C);

    // Reserved register 6 read behaves as the control register.
    clr_mon();
    rd_byte = 8'h77;
    issue(3'd6, 1'b0, 8'h00, 1'b0);
    wait_idle();
    chk("rsv_latency", 32'(last_lat), 32'd2);
    chk("rsv_addr0_cycles", 32'(lo_cnt[0]), 32'd1);
    chk("rsv_rsp_data", 32'(bus.RSP_DATA), 32'h77);

    // Back-to-back R3 writes with CMD_VALID held high.
    clr_mon();
    script = '{8'h40};
    issue(3'd3, 1'b1, 8'h11, 1'b1);
    issue(3'd3, 1'b1, 8'h22, 1'b0);
    chk("b2b_accept_gap", 32'(acc_cyc - rv_cyc), 32'd2);
    wait_idle();
    chk("b2b_data_count", 32'(wr_seen.size()), 32'd2);
    chk("b2b_first", 32'((wr_seen.size() > 0) ? wr_seen[0] : 8'h00), 32'h11);
    chk("b2b_second", 32'((wr_seen.size() > 1) ? wr_seen[1] : 8'h00), 32'h22);
    chk("b2b_polls", 32'(lo_cnt[4]), 32'd2);

    // Reset asserted for three clocks while an R1 write is in its data cycle.
    clr_mon();
    script = '{8'h40};
    issue(3'd1, 1'b1, 8'h33, 1'b0);
    step();
    step();
    RST = 1'b1;
    repeat (3) step();
    RST = 1'b0;
    @(negedge HO2);
    #1;
    chk("rst_mid_ready", 32'(bus.CMD_READY), 32'd1);
    chk("rst_mid_hcs", 32'(bus.HCS), 32'd1);
    chk("rst_mid_hdoe", 32'(bus.HDOE), 32'd0);
    chk("rst_mid_rsp_data", 32'(bus.RSP_DATA), 32'h00);
    repeat (4) step();
    chk("rst_mid_no_rsp", 32'(rv_cnt), 32'd0);

`ifdef TUBE_HOST_TIMEOUT_EN
    // R2 read with status stuck not-available: aborts after TB_LIMIT polls.
    clr_mon();
    script = '{8'h40};
    issue(3'd2, 1'b0, 8'h00, 1'b0);
    wait_idle();
    chk("to_polls", 32'(lo_cnt[2]), 32'd4);
    chk("to_no_data", 32'(lo_cnt[3]), 32'd0);
    chk("to_err", 32'(last_err), 32'd1);
    chk("to_rsp_data", 32'(bus.RSP_DATA), 32'h40);
    chk("to_latency", 32'(last_lat), 32'd9);
`else
    // R2 read with a long not-available run still completes without error.
    clr_mon();
    script  = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h80};
    rd_byte = 8'h9E;
    issue(3'd2, 1'b0, 8'h00, 1'b0);
    wait_idle();
    chk("nt_polls", 32'(lo_cnt[2]), 32'd6);
    chk("nt_err", 32'(last_err), 32'd0);
    chk("nt_rsp_data", 32'(bus.RSP_DATA), 32'h9E);
    chk("nt_latency", 32'(last_lat), 32'd14);
`endif

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/tube_host_master.md
Name: tube_host_master

Overview:
- Synthesisable host-side bus initiator that drives the host port of tube_ula (HCS/HA/HRW/HD) on behalf of an internal command interface.
- Performs status-polled byte transfers on Tube registers R1-R4: poll the status register, then access the data register.
- Also issues direct accesses to the control register (address 0).
- Sits between an on-chip host CPU model or DMA engine and the ULA, so host-to-parasite traffic can run in hardware.

Parameters:
- POLL_WIDTH, 8, width of the poll retry counter.
- POLL_LIMIT, 255, maximum status polls before a command aborts (used only with TUBE_HOST_TIMEOUT_EN).

Ports:
- HO2  in  1  bus clock; one clock = one host bus cycle.
- RST  in  1  synchronous, active-high reset.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  command accepted when CMD_VALID & CMD_READY at a rising edge.
- CMD_REG  in  3  0 = control register; 1-4 = Tube register R1-R4; 5-7 reserved, treated as 0.
- CMD_WRITE  in  1  1 = write, 0 = read.
- CMD_DATA  in  8  write data.
- RSP_VALID  out  1  one-clock completion pulse.
- RSP_DATA  out  8  read data, or last status byte on timeout.
- RSP_ERR  out  1  poll timeout flag, valid with RSP_VALID.
- HCS  out  1  active-low ULA host chip select.
- HA  out  3  ULA host address.
- HRW  out  1  1 = read, 0 = write.
- HDOUT  out  8  data driven to the ULA.
- HDOE  out  1  HDOUT drive enable.
- HDIN  in  8  data returned by the ULA.

Behaviour:
- All outputs are registered except CMD_READY, which is 1 exactly when the state is IDLE and RST = 0.
- Reset values: HCS=1, HA=000, HRW=1, HDOUT=00, HDOE=0, RSP_VALID=0, RSP_DATA=00, RSP_ERR=0, poll counter=0, state=IDLE.
- Reset asserted mid-command aborts the command: no response is generated, and HCS is 1 in the clock after the reset edge.
- Address map for register n = 1..4: status address {n-1,0}, data address {n-1,1}.
- Condition flags: write proceeds when status bit6 (not full) = 1; read proceeds when status bit7 (data available) = 1.
- IDLE
  - HCS=1.
  - On handshake, latch reg, direction and data, and clear the poll counter.
  - Go to XFER if reg = 0, else go to POLL.
- POLL
  - HCS=0, HA=status address, HRW=1, HDOE=0.
  - HDIN is captured into the status register at the closing edge.
- CHECK
  - HCS=1; this is the mandatory idle gap.
  - If the condition flag is set, go to XFER.
  - Else increment the poll counter and go to POLL.
- XFER
  - HCS=0, HA = data address (000 for reg 0), HRW = ~write.
  - Write: HDOUT = latched data, HDOE = 1.
  - Read: HDIN is captured into RSP_DATA at the closing edge.
- DONE
  - HCS=1, HDOE=0, RSP_VALID=1 for one clock, then go to IDLE.
  - RSP_DATA keeps its value until the next read or timeout. On a write, RSP_DATA is unchanged.
- Latency in clocks from the accept edge to RSP_VALID high: reg 0 = 2; reg 1-4 = 4 + 2×(failed polls).
- HCS is never low on two consecutive clocks.
- Minimum spacing between accepts is the state path above plus one IDLE clock.
- The poll counter saturates at all-ones and never wraps.

Optional Feature:
- TUBE_HOST_TIMEOUT_EN defined:
  - In CHECK with the condition flag clear, if poll counter == POLL_LIMIT-1, go to DONE with RSP_ERR=1 and RSP_DATA = last status byte.
  - No data cycle is issued.
- Not defined:
  - Polling continues indefinitely and RSP_ERR is tied 0.
  - POLL_LIMIT is ignored.

Test Plan:
- Reset: assert RST for 3 clocks during XFER of an R1 write -> HCS=1, HDOE=0, RSP_VALID never pulses; CMD_READY=1 the first clock after release.
- R1 write 0xAA, status returns 0x40 -> bus trace: HA=000 read, idle, HA=001 HRW=0 HDOUT=0xAA HDOE=1; RSP_VALID 4 clocks after accept, RSP_ERR=0.
- R4 read, status 0x00 for 3 polls then 0x80, data 0x5C -> four HA=110 reads, then HA=111 read; RSP_DATA=0x5C, RSP_VALID 10 clocks after accept.
- Control write reg 0 data 0xA0 -> single HCS-low clock, HA=000 HRW=0 HDOUT=0xA0; RSP_VALID 2 clocks after accept, no status poll.
- With TUBE_HOST_TIMEOUT_EN and POLL_LIMIT=4, R2 read with status stuck at 0x40 -> exactly 4 HA=010 polls, no HA=011 access; RSP_ERR=1, RSP_DATA=0x40.
- CMD_VALID held high for two R3 writes (0x11, 0x22), status 0x40 -> second command accepted in the IDLE clock after the first RSP_VALID; data cycles carry 0x11 then 0x22; no consecutive HCS-low clocks.
